crc32_frame_ctrl: RTL



---
 rtl/crc_pkg.sv | 20 ++
 rtl/crc.sv | 21 ++
 rtl/crc32_frame_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - CRC-32 constants and frame controller encodings shared by crc and crc32_frame_ctrl
package crc_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_FCS  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_APPEND = 1'b0,
    MODE_CHECK  = 1'b1
  } mode_t;

  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOROUT  = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/crc.sv
// rtl/crc.sv - combinational reflected CRC-32 update for one input byte
module crc
  import crc_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] acc;

  // LSB-first shift: one polynomial reduction per input bit
  always_comb begin
    acc = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ CRC32_POLY) : (acc >> 1);
    end
    crc_out = acc;
  end

endmodule

// File: rtl/crc32_frame_ctrl.sv
// rtl/crc32_frame_ctrl.sv - byte-stream CRC-32 framer: appends or checks FCS per frame
// Optional frame/error counters under CRC_FRAME_STATS_EN.
module crc32_frame_ctrl
  import crc_pkg::*;
#(
  parameter logic [31:0] CRC_INIT    = CRC32_INIT,
  parameter logic [31:0] CRC_XOROUT  = CRC32_XOROUT,
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        done,
  output logic        crc_ok,
  output logic        short_err,
  output logic [31:0] crc_value
`ifdef CRC_FRAME_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
`endif
);

  state_t      state;
  logic [31:0] crc_reg;
  logic [31:0] crc_in;
  logic [31:0] crc_next;
  logic [31:0] fcs_word;
  logic [2:0]  count;
  logic [2:0]  count_next;
  logic [1:0]  fcs_idx;
  logic        mode_reg;
  logic        cur_mode;
  logic        accept;
  logic        short_frame;
  logic        chk_ok;
  logic        fin_chk;
  logic        fin_app;

  crc u_crc (
    .crc_in  (crc_in),
    .data    (in_data),
    .crc_out (crc_next)
  );

  assign cur_mode    = (state == S_IDLE) ? mode : mode_reg;
  assign crc_in      = (state == S_IDLE) ? CRC_INIT : crc_reg;
  assign count_next  = (state == S_IDLE) ? 3'd1 : ((count == 3'd4) ? 3'd4 : count + 3'd1);
  assign short_frame = (count_next < 3'd4);
  assign chk_ok      = (crc_next == CRC_RESIDUE) && !short_frame;
  assign accept      = in_valid && in_ready;
  assign fin_chk     = accept && in_last && (state != S_FCS) && (cur_mode == MODE_CHECK);
  assign fin_app     = (state == S_FCS) && out_ready && (fcs_idx == 2'd3);

  // Pass-through is zero latency, so the byte interface is combinational
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE, S_DATA: begin
          in_ready  = out_ready;
          out_valid = in_valid;
          out_data  = in_data;
          out_last  = in_last && (cur_mode == MODE_CHECK);
        end
        S_FCS: begin
          out_valid = 1'b1;
          out_data  = fcs_word[{fcs_idx, 3'b000} +: 8];
          out_last  = (fcs_idx == 2'd3);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      crc_reg   <= CRC_INIT;
      count     <= 3'd0;
      mode_reg  <= 1'b0;
      fcs_word  <= 32'h0;
      fcs_idx   <= 2'd0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      short_err <= 1'b0;
      crc_value <= 32'h0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DATA: begin
          if (accept) begin
            crc_reg  <= crc_next;
            count    <= count_next;
            mode_reg <= cur_mode;
            state    <= S_DATA;
            if (in_last) begin
              if (cur_mode == MODE_CHECK) begin
                done      <= 1'b1;
                crc_ok    <= chk_ok;
                short_err <= short_frame;
                crc_value <= crc_next ^ CRC_XOROUT;
                state     <= S_IDLE;
                crc_reg   <= CRC_INIT;
                count     <= 3'd0;
              end else begin
                fcs_word <= crc_next ^ CRC_XOROUT;
                fcs_idx  <= 2'd0;
                state    <= S_FCS;
              end
            end
          end
        end
        S_FCS: begin
          if (out_ready) begin
            if (fin_app) begin
              done      <= 1'b1;
              crc_ok    <= 1'b0;
              short_err <= 1'b0;
              crc_value <= fcs_word;
              state     <= S_IDLE;
              crc_reg   <= CRC_INIT;
              count     <= 3'd0;
            end else begin
              fcs_idx <= fcs_idx + 2'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef CRC_FRAME_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= 16'h0;
      err_cnt   <= 16'h0;
    end else begin
      if ((fin_chk || fin_app) && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
      if (fin_chk && !chk_ok && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  logic unused_fin;
  assign unused_fin = fin_chk;
`endif

endmodule
